// File: rtl/mem_access_unit.sv
// Load/store unit between a request/response handshake and a single-port data memory.
// Handles byte/half/word accesses with sign/zero extension and read-modify-write sub-word stores.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  state_t      state;
  logic        store_reg;
  logic [2:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  function automatic logic req_error(input logic st, input logic [2:0] sz, input logic [31:0] a);
    logic [32:0] last_byte;
    logic        bad;
    // Range check uses the whole aligned word, computed one bit wider so it cannot wrap.
    last_byte = {1'b0, a[31:2], 2'b00} + 33'd3;
    bad = 1'b0;
    case (sz)
      SZ_B, SZ_BU: bad = 1'b0;
      SZ_H, SZ_HU: bad = a[0];
      SZ_W:        bad = (a[1:0] != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (st && sz[2]) bad = 1'b1;
    if (last_byte >= MEM_LIMIT) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] sz,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_BU:   r = {24'h000000, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_HU:   r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] sz,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    case (sz)
      SZ_B: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      SZ_H: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_err   <= 1'b0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      store_reg  <= 1'b0;
      size_reg   <= 3'b000;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_reg <= req_store;
            size_reg  <= req_size;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            req_ready <= 1'b0;
            if (req_error(req_store, req_size, req_addr)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= 32'h0;
              resp_err   <= 1'b1;
            end else if (req_store && (req_size == SZ_W)) begin
              state     <= WRITE;
              mem_ce    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
            end else begin
              state    <= READ;
              mem_ce   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        READ: begin
          if (store_reg) begin
            // Sub-word store: patch the freshly read word and write it back next cycle.
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_addr  <= {addr_reg[31:2], 2'b00};
            mem_wdata <= store_merge(mem_rdata, size_reg, addr_reg[1:0], wdata_reg);
          end else begin
            state      <= RESP;
            mem_ce     <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= load_extract(mem_rdata, size_reg, addr_reg[1:0]);
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_ce     <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_data  <= 32'h0;
          resp_err   <= 1'b0;
        end
        default: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit against a byte-array memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int MB = 1020;
  localparam int NW = MB / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          id;
    int          issue_cyc;
    int          lat;
    int          ce_base;
    int          we_base;
    int          ce_exp;
    int          we_exp;
    int          hold;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pcyc = 0;
  int         ce_cnt = 0;
  int         we_cnt = 0;
  int         align_bad = 0;
  int         next_id = 0;
  bit         pending = 0;
  logic [7:0] ref_mem [0:MB-1];
  logic [31:0] mem [0:NW-1];

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h01000193) ^ 32'hC3A55A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(posedge clk) pcyc <= pcyc + 1;

  always_comb begin
    mem_rdata = 32'hDEADBEEF;
    if (mem_ce && !mem_we && (mem_addr[31:2] < 30'(NW)))
      mem_rdata = mem[mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (!rst_n && pcyc < 3) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
    end else if (mem_ce) begin
      ce_cnt <= ce_cnt + 1;
      if (mem_addr[1:0] != 2'b00) align_bad <= align_bad + 1;
      if (mem_we) begin
        we_cnt <= we_cnt + 1;
        if (mem_addr[31:2] < 30'(NW)) mem[mem_addr[9:2]] <= mem_wdata;
      end
    end
  end

  // Reference behaviour from the access rules, on a flat byte array.
  task automatic model(input logic st, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    longint base;
    bit     bad;
    int     ia;
    logic [7:0] b0, b1, b2, b3;
    base = longint'({32'h0, a & 32'hFFFFFFFC});
    bad = !(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (st && sz[2]) ||
          ((sz == 3'd1 || sz == 3'd5) && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
          (base + 3 >= longint'(MB));
    e.data = 32'h0; e.err = 1'b0; e.lat = 1; e.ce_exp = 0; e.we_exp = 0;
    if (bad) begin
      e.err = 1'b1;
    end else begin
      ia = int'(a[9:0]);
      if (!st) begin
        b0 = ref_mem[ia];
        b1 = (sz != 3'd0 && sz != 3'd4) ? ref_mem[ia+1] : 8'h00;
        b2 = (sz == 3'd2) ? ref_mem[ia+2] : 8'h00;
        b3 = (sz == 3'd2) ? ref_mem[ia+3] : 8'h00;
        case (sz)
          3'd0:    e.data = {{24{b0[7]}}, b0};
          3'd4:    e.data = {24'h0, b0};
          3'd1:    e.data = {{16{b1[7]}}, b1, b0};
          3'd5:    e.data = {16'h0, b1, b0};
          default: e.data = {b3, b2, b1, b0};
        endcase
        e.lat = 2; e.ce_exp = 1;
      end else begin
        ref_mem[ia] = wd[7:0];
        if (sz != 3'd0) ref_mem[ia+1] = wd[15:8];
        if (sz == 3'd2) begin
          ref_mem[ia+2] = wd[23:16];
          ref_mem[ia+3] = wd[31:24];
          e.lat = 2; e.ce_exp = 1;
        end else begin
          e.lat = 3; e.ce_exp = 2;
        end
        e.we_exp = 1;
      end
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input bit track);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      req_valid = 1'($urandom_range(0, 1));
      req_store = 1'($urandom_range(0, 1));
      req_size  = 3'($urandom_range(0, 7));
      req_addr  = 32'($urandom_range(0, 1023));
      req_wdata = $urandom;
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
    if (track) begin
      model(st, sz, a, wd, e);
      e.id = next_id; e.issue_cyc = pcyc; e.ce_base = ce_cnt; e.we_base = we_cnt; e.hold = hold;
      next_id++;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t        cur;
    logic [31:0] hd;
    logic        he;
    int          hold_left, wait_cnt;
    bit          rr_prev;
    rr_prev = 0; hold_left = 0; wait_cnt = 0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 0; rr_prev = 0; resp_ready = 1'b0;
        continue;
      end
      if (pending && rr_prev) begin
        chk("resp_release", 32'(resp_valid), 32'd0);
        pending = 0;
      end
      if (pending) begin
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", resp_data, hd);
        chk("hold_err", 32'(resp_err), 32'(he));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        wait_cnt++;
        if (wait_cnt > 50) begin
          chk("resp_stuck", 32'(wait_cnt), 32'd0);
          pending = 0;
        end
      end else if (resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          cur = sb_q.pop_front();
          $display("resp id=%0d data=%h err=%0d lat=%0d", cur.id, resp_data, resp_err,
                   pcyc - cur.issue_cyc);
          chk("resp_data", resp_data, cur.data);
          chk("resp_err", 32'(resp_err), 32'(cur.err));
          chk("latency", 32'(pcyc - cur.issue_cyc), 32'(cur.lat));
          chk("ce_cycles", 32'(ce_cnt - cur.ce_base), 32'(cur.ce_exp));
          chk("we_cycles", 32'(we_cnt - cur.we_base), 32'(cur.we_exp));
          pending = 1; hd = resp_data; he = resp_err; hold_left = cur.hold; wait_cnt = 0;
        end
      end
      if (pending) begin
        if (hold_left > 0) begin
          resp_ready = 1'b0;
          hold_left--;
        end else begin
          resp_ready = 1'b1;
        end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
      rr_prev = pending && resp_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          bad_words, snap_we, drain;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < NW; i++) begin
      a = init_word(i);
      ref_mem[4*i] = a[7:0]; ref_mem[4*i+1] = a[15:8];
      ref_mem[4*i+2] = a[23:16]; ref_mem[4*i+3] = a[31:24];
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    issue(1'b0, 3'b100, 32'h12, 32'h0, 0, 1);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 0, 1);
    issue(1'b0, 3'b001, 32'h10, 32'h0, 1, 1);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 0, 1);
    issue(1'b1, 3'b000, 32'h11, 32'h0000005A, 0, 1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 0, 1);
    issue(1'b0, 3'b010, 32'h0E, 32'h0, 0, 1);
    issue(1'b1, 3'b100, 32'h20, 32'h12345678, 0, 1);
    issue(1'b0, 3'b010, 32'h3FC, 32'h0, 0, 1);
    issue(1'b0, 3'b011, 32'h20, 32'h0, 0, 1);
    issue(1'b0, 3'b001, 32'h21, 32'h0, 0, 1);
    issue(1'b1, 3'b101, 32'h22, 32'h0, 0, 1);
    issue(1'b1, 3'b001, 32'h3FA, 32'hBEEF, 0, 1);
    issue(1'b1, 3'b010, 32'h3F8, 32'hCAFEF00D, 0, 1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 5, 1);
    issue(1'b0, 3'b000, 32'h23, 32'h0, 5, 1);

    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            $urandom_range(0, 2), 1);
    end

    drain = 0;
    while ((sb_q.size() != 0 || pending) && drain < 200) begin
      @(negedge clk);
      drain++;
    end
    chk("drain_before_abort", 32'(sb_q.size()), 32'd0);

    issue(1'b1, 3'b000, 32'h24, 32'h000000A5, 0, 0);
    chk("abort_in_read_ce", 32'(mem_ce), 32'd1);
    chk("abort_in_read_we", 32'(mem_we), 32'd0);
    snap_we = we_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_ce", 32'(mem_ce), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(we_cnt - snap_we), 32'd0);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 3'b010, 32'h24, 32'h0, 0, 1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 0, 1);
    drain = 0;
    while ((sb_q.size() != 0 || pending) && drain < 200) begin
      @(negedge clk);
      drain++;
    end
    chk("final_drain", 32'(sb_q.size()), 32'd0);

    bad_words = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]})
        bad_words++;
    chk("mem_image_bad_words", 32'(bad_words), 32'd0);
    chk("mem_addr_alignment", 32'(align_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
